// File: rtl/matrix_processor_p_if.sv
// -----------------------------------------------------------------------------
// matrix_processor_p_if
// Bundles the operand-stream input and the result-RAM write port of
// matrix_processor_p.
//
// Handshake: there is no backpressure. A source raises en while the processor
// is idle (busy=0); the processor then samples data_in once per cycle. The
// first word is the opcode and the remaining words are the operands. Each
// cycle with write_en=1 carries one result word (data_out at address). done
// pulses for one cycle at completion, and err/ovf are valid in that cycle.
//
// Signals:
//   en        source -> proc   start request
//   data_in   source -> proc   opcode/operand word
//   data_out  proc   -> RAM    result word
//   address   proc   -> RAM    result write address
//   write_en  proc   -> RAM    result write strobe
//   done      proc   -> source completion pulse
//   err       proc   -> source illegal opcode (valid with done)
//   ovf       proc   -> source saturation/wrap occurred (valid with done)
//   busy      proc   -> source operation in progress
// -----------------------------------------------------------------------------
interface matrix_processor_p_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic [AW-1:0] address;
  logic          write_en;
  logic          done;
  logic          err;
  logic          ovf;
  logic          busy;

  modport master (
    output en, data_in,
    input  data_out, address, write_en, done, err, ovf, busy
  );

  modport slave (
    input  en, data_in,
    output data_out, address, write_en, done, err, ovf, busy
  );
endinterface

// File: rtl/matrix_processor_p.sv
// -----------------------------------------------------------------------------
// matrix_processor_p
// Streams in an opcode and 2x2 signed operand matrices, computes one result
// (add, sub, mul, det, trans, scalar mul), and writes the result words to the
// result RAM at OUT_BASE, OUT_BASE-1, ... Each result is saturated (SAT=1) or
// wrapped (SAT=0) to DW bits.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   bus          matrix_processor_p_if.slave (stream in, RAM write port out)
//   o_dbg_state  current FSM state, for observation only
// -----------------------------------------------------------------------------
module matrix_processor_p #(
  parameter int          DW       = 8,
  parameter int          AW       = 8,
  parameter int unsigned OUT_BASE = 2**AW - 1,
  parameter bit          SAT      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  matrix_processor_p_if.slave  bus,
  output logic [2:0]           o_dbg_state
);

  localparam int FW = 2*DW + 1;                 // full-precision width
  localparam logic [AW-1:0] BASE = AW'(OUT_BASE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_CAL    = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]           r_state;
  logic [2:0]           r_cnt;
  logic [2:0]           r_op;
  logic [DW-1:0]        r_w   [0:7];
  logic signed [FW-1:0] r_res [0:3];
  logic [DW-1:0]        r_data_out;
  logic [AW-1:0]        r_address;
  logic                 r_write_en;
  logic                 r_done;
  logic                 r_err;
  logic                 r_ovf;
  logic                 r_busy;

  logic signed [FW-1:0] w_x   [0:7];
  logic signed [FW-1:0] w_res [0:3];
  logic signed [FW-1:0] w_v;
  logic [2:0]           w_n_last;
  logic [2:0]           w_m_last;
  logic                 w_illegal;
  logic                 w_fits;
  logic [DW-1:0]        w_out_word;

  // Opcode legality is judged on the raw FETCH word: only 0..5 with zero
  // upper bits is accepted.
  assign w_illegal = (bus.data_in[2:0] > 3'd5) | (|bus.data_in[DW-1:3]);

  // Last READ / OUT index per opcode (word count minus one).
  always_comb begin
    w_n_last = 3'd0;
    w_m_last = 3'd0;
    case (r_op)
      3'd0, 3'd1, 3'd2: begin w_n_last = 3'd7; w_m_last = 3'd3; end
      3'd3:             begin w_n_last = 3'd3; w_m_last = 3'd0; end
      3'd4:             begin w_n_last = 3'd3; w_m_last = 3'd3; end
      3'd5:             begin w_n_last = 3'd4; w_m_last = 3'd3; end
      default:          begin w_n_last = 3'd0; w_m_last = 3'd0; end
    endcase
  end

  // Operands sign-extended to full precision; DW x DW products and their
  // pairwise sums always fit in FW bits, so nothing here can overflow.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_x[i] = {{(FW-DW){r_w[i][DW-1]}}, r_w[i]};
    end
  end

  // Stream layout: A,B,C,D in words 0..3 and a,b,c,d in words 4..7; for
  // smul, k is word 0 and A..D are words 1..4.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_res[i] = '0;
    end
    case (r_op)
      3'd0: begin
        w_res[0] = w_x[0] + w_x[4];
        w_res[1] = w_x[1] + w_x[5];
        w_res[2] = w_x[2] + w_x[6];
        w_res[3] = w_x[3] + w_x[7];
      end
      3'd1: begin
        w_res[0] = w_x[0] - w_x[4];
        w_res[1] = w_x[1] - w_x[5];
        w_res[2] = w_x[2] - w_x[6];
        w_res[3] = w_x[3] - w_x[7];
      end
      3'd2: begin
        w_res[0] = w_x[0] * w_x[4] + w_x[1] * w_x[6];
        w_res[1] = w_x[0] * w_x[5] + w_x[1] * w_x[7];
        w_res[2] = w_x[2] * w_x[4] + w_x[3] * w_x[6];
        w_res[3] = w_x[2] * w_x[5] + w_x[3] * w_x[7];
      end
      3'd3: begin
        w_res[0] = w_x[0] * w_x[3] - w_x[1] * w_x[2];
      end
      3'd4: begin
        w_res[0] = w_x[0];
        w_res[1] = w_x[2];
        w_res[2] = w_x[1];
        w_res[3] = w_x[3];
      end
      3'd5: begin
        w_res[0] = w_x[0] * w_x[1];
        w_res[1] = w_x[0] * w_x[2];
        w_res[2] = w_x[0] * w_x[3];
        w_res[3] = w_x[0] * w_x[4];
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          w_res[i] = '0;
        end
      end
    endcase
  end

  // A value fits the signed DW range exactly when its bits FW-1..DW-1 are all
  // copies of the sign; otherwise clamp toward the sign or keep the low bits.
  assign w_v    = r_res[r_cnt[1:0]];
  assign w_fits = (&w_v[FW-1:DW-1]) | ~(|w_v[FW-1:DW-1]);

  always_comb begin
    w_out_word = w_v[DW-1:0];
    if (SAT && !w_fits) begin
      w_out_word = w_v[FW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_op       <= 3'd0;
      r_data_out <= '0;
      r_address  <= BASE;
      r_write_en <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_w[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        r_res[i] <= '0;
      end
    end else begin
      // Single-cycle strobes and the idle address unless a state sets them.
      r_write_en <= 1'b0;
      r_done     <= 1'b0;
      r_address  <= BASE;
      case (r_state)
        S_IDLE: begin
          if (bus.en) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= 3'd0;
          end
        end
        S_FETCH: begin
          r_op  <= bus.data_in[2:0];
          r_cnt <= 3'd0;
          if (w_illegal) begin
            r_err   <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_state <= S_READ;
          end
        end
        S_READ: begin
          r_w[r_cnt] <= bus.data_in;
          if (r_cnt == w_n_last) begin
            r_cnt   <= 3'd0;
            r_state <= S_CAL;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_CAL: begin
          r_res   <= w_res;
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_write_en <= 1'b1;
          r_data_out <= w_out_word;
          r_address  <= BASE - AW'(r_cnt);
          if (!w_fits) begin
            r_ovf <= 1'b1;
          end
          if (r_cnt == w_m_last) begin
            r_cnt   <= 3'd0;
            r_state <= S_FINISH;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.address  = r_address;
  assign bus.write_en = r_write_en;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.ovf      = r_ovf;
  assign bus.busy     = r_busy;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_matrix_processor_p.sv
module tb_matrix_processor_p;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int OUT_BASE = 255;
  localparam longint MAXV = (64'sd1 <<< (DW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (DW-1));

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [2:0] dbg_sat, dbg_wrap;

  always #5 clk = ~clk;

  matrix_processor_p_if #(.DW(DW), .AW(AW)) if_sat ();
  matrix_processor_p_if #(.DW(DW), .AW(AW)) if_wrap ();

  assign if_sat.en       = en;
  assign if_sat.data_in  = data_in;
  assign if_wrap.en      = en;
  assign if_wrap.data_in = data_in;

  matrix_processor_p #(.DW(DW), .AW(AW), .OUT_BASE(OUT_BASE), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .bus(if_sat), .o_dbg_state(dbg_sat)
  );
  matrix_processor_p #(.DW(DW), .AW(AW), .OUT_BASE(OUT_BASE), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .bus(if_wrap), .o_dbg_state(dbg_wrap)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+DW-1:0] exp_sat_q[$];
  logic [AW+DW-1:0] exp_wrap_q[$];

  int     wv[8];          // operand words of the next operation
  longint m_res[4];       // full-precision expected results
  int     m_n, m_m;
  bit     m_illegal;
  bit     m_ovf;

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] sat_word(input longint v);
    longint t;
    t = (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] wrap_word(input longint v);
    longint t;
    t = v;
    return t[DW-1:0];
  endfunction

  function automatic void model(input logic [DW-1:0] op_word);
    longint ma, mb, mc, md, xa, xb, xc, xd, k;
    int op;
    op = int'(op_word[2:0]);
    m_illegal = (op_word[DW-1:3] != 0) || (op > 5);
    ma = wv[0]; mb = wv[1]; mc = wv[2]; md = wv[3];
    xa = wv[4]; xb = wv[5]; xc = wv[6]; xd = wv[7];
    k  = wv[0];
    for (int i = 0; i < 4; i++) m_res[i] = 0;
    m_n = 0; m_m = 0;
    if (!m_illegal) begin
      case (op)
        0: begin m_n = 8; m_m = 4; m_res = '{ma+xa, mb+xb, mc+xc, md+xd}; end
        1: begin m_n = 8; m_m = 4; m_res = '{ma-xa, mb-xb, mc-xc, md-xd}; end
        2: begin m_n = 8; m_m = 4;
                 m_res = '{ma*xa+mb*xc, ma*xb+mb*xd, mc*xa+md*xc, mc*xb+md*xd}; end
        3: begin m_n = 4; m_m = 1; m_res[0] = ma*md - mb*mc; end
        4: begin m_n = 4; m_m = 4; m_res = '{ma, mc, mb, md}; end
        default: begin m_n = 5; m_m = 4;
                 m_res = '{k*longint'(wv[1]), k*longint'(wv[2]),
                           k*longint'(wv[3]), k*longint'(wv[4])}; end
      endcase
    end
    m_ovf = 1'b0;
    for (int i = 0; i < m_m; i++) begin
      if (m_res[i] > MAXV || m_res[i] < MINV) m_ovf = 1'b1;
    end
  endfunction

  // ---------------- driver + checker for one operation ----------------
  // Raises en, lets the next edge accept, then feeds opcode and operands and
  // checks every write, the done cycle, err, ovf and busy of both instances.
  task automatic run_op(input logic [DW-1:0] op_word, input bit keep_en, input string name);
    int exp_lat;
    int busy_bad;
    bit got_done;
    logic [AW+DW-1:0] exp_w, got_w;
    model(op_word);
    for (int i = 0; i < m_m; i++) begin
      exp_sat_q.push_back({AW'(OUT_BASE - i), sat_word(m_res[i])});
      exp_wrap_q.push_back({AW'(OUT_BASE - i), wrap_word(m_res[i])});
    end
    exp_lat = m_illegal ? 3 : (m_n + m_m + 4);

    n_checks++;
    if (if_sat.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_before_start: busy=%b want 0", name, if_sat.busy);
    end

    en = 1'b1;
    data_in = DW'($urandom);
    @(posedge clk); #1;                       // accept edge, cycle 0
    if (!keep_en) en = 1'b0;
    data_in = op_word;
    got_done = 1'b0;
    busy_bad = 0;
    for (int e = 1; e <= 40 && !got_done; e++) begin
      @(posedge clk); #1;
      if (if_sat.write_en === 1'b1) begin
        got_w = {if_sat.address, if_sat.data_out};
        exp_w = (exp_sat_q.size() > 0) ? exp_sat_q.pop_front() : 'x;
        n_checks++;
        if (got_w !== exp_w) begin
          n_fail++;
          $display("FAIL %s write_sat: got addr %0d data %0d, want addr %0d data %0d",
                   name, got_w[AW+DW-1:DW], $signed(got_w[DW-1:0]),
                   exp_w[AW+DW-1:DW], $signed(exp_w[DW-1:0]));
        end
      end
      if (if_wrap.write_en === 1'b1) begin
        got_w = {if_wrap.address, if_wrap.data_out};
        exp_w = (exp_wrap_q.size() > 0) ? exp_wrap_q.pop_front() : 'x;
        n_checks++;
        if (got_w !== exp_w) begin
          n_fail++;
          $display("FAIL %s write_wrap: got addr %0d data %0d, want addr %0d data %0d",
                   name, got_w[AW+DW-1:DW], $signed(got_w[DW-1:0]),
                   exp_w[AW+DW-1:DW], $signed(exp_w[DW-1:0]));
        end
      end
      if (if_sat.done === 1'b1) begin
        got_done = 1'b1;
        n_checks++;
        if (e + 1 != exp_lat) begin
          n_fail++;
          $display("FAIL %s done_cycle: got %0d want %0d", name, e + 1, exp_lat);
        end
        n_checks++;
        if (if_wrap.done !== 1'b1) begin
          n_fail++;
          $display("FAIL %s done_wrap: got %b want 1", name, if_wrap.done);
        end
        n_checks++;
        if (if_sat.err !== m_illegal || if_wrap.err !== m_illegal) begin
          n_fail++;
          $display("FAIL %s err: got %b/%b want %b", name, if_sat.err, if_wrap.err, m_illegal);
        end
        n_checks++;
        if (if_sat.ovf !== m_ovf || if_wrap.ovf !== m_ovf) begin
          n_fail++;
          $display("FAIL %s ovf: got %b/%b want %b", name, if_sat.ovf, if_wrap.ovf, m_ovf);
        end
        n_checks++;
        if (exp_sat_q.size() != 0 || exp_wrap_q.size() != 0) begin
          n_fail++;
          $display("FAIL %s missing_writes: got %0d/%0d left want 0", name,
                   exp_sat_q.size(), exp_wrap_q.size());
        end
        n_checks++;
        if (if_sat.busy !== 1'b0 || if_wrap.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy_at_done: got %b/%b want 0", name, if_sat.busy, if_wrap.busy);
        end
      end else if (if_sat.busy !== 1'b1 || if_wrap.busy !== 1'b1) begin
        busy_bad++;
      end
      data_in = (e - 1 < m_n) ? DW'(wv[e - 1]) : DW'($urandom);
    end
    n_checks++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL %s done_timeout: got no done in 40 cycles want cycle %0d", name, exp_lat);
    end
    n_checks++;
    if (busy_bad != 0) begin
      n_fail++;
      $display("FAIL %s busy_during_op: got %0d low cycles want 0", name, busy_bad);
    end
    exp_sat_q.delete();
    exp_wrap_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if_sat.write_en, if_sat.done, if_sat.err, if_sat.ovf, if_sat.busy} !== 5'b0 ||
        if_sat.address !== AW'(OUT_BASE) || if_sat.data_out !== '0 ||
        {if_wrap.write_en, if_wrap.done, if_wrap.err, if_wrap.ovf, if_wrap.busy} !== 5'b0 ||
        if_wrap.address !== AW'(OUT_BASE) || if_wrap.data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got we%b d%b e%b o%b b%b a%0d q%0d want all 0, addr %0d",
               if_sat.write_en, if_sat.done, if_sat.err, if_sat.ovf, if_sat.busy,
               if_sat.address, if_sat.data_out, OUT_BASE);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sat_wrap();
    wv = '{100, -100, 5, 0, 50, -50, 3, 0};
    run_op(8'd0, 1'b0, "add");
  endtask

  task automatic test_mul_det();
    wv = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_op(8'd2, 1'b0, "mul");
    wv = '{3, 8, 4, 6, 0, 0, 0, 0};
    run_op(8'd3, 1'b0, "det");
  endtask

  task automatic test_back_to_back();
    wv = '{1, 2, 3, 4, 0, 0, 0, 0};
    run_op(8'd4, 1'b1, "trans");              // en stays high throughout
    wv = '{-2, 1, 2, 3, 4, 0, 0, 0};
    run_op(8'd5, 1'b0, "smul");               // accepted in the first IDLE cycle
  endtask

  task automatic test_illegal();
    wv = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_op(8'd7, 1'b0, "illegal7");
    @(posedge clk); #1;
    n_checks++;
    if (if_sat.done !== 1'b0 || if_sat.busy !== 1'b0 || if_sat.err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_after_done: got done %b busy %b err %b want 0 0 1",
               if_sat.done, if_sat.busy, if_sat.err);
    end
    run_op(8'h18, 1'b0, "illegal_upper");     // legal low bits, nonzero upper bits
    wv = '{7, -3, 2, 9, 0, 0, 0, 0};
    run_op(8'd4, 1'b0, "trans_after_illegal");
  endtask

  task automatic test_reset_mid_op();
    int writes;
    int stray;
    logic [AW+DW-1:0] exp_w, got_w;
    writes = 0;
    wv = '{1, 2, 3, 4, 5, 6, 7, 8};
    model(8'd2);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    data_in = 8'd2;
    for (int e = 1; e <= 40 && writes < 2; e++) begin
      @(posedge clk); #1;
      if (if_sat.write_en === 1'b1) begin
        got_w = {if_sat.address, if_sat.data_out};
        exp_w = {AW'(OUT_BASE - writes), sat_word(m_res[writes])};
        n_checks++;
        if (got_w !== exp_w) begin
          n_fail++;
          $display("FAIL rst_mid write%0d: got %h want %h", writes, got_w, exp_w);
        end
        writes++;
      end
      data_in = (e - 1 < 8) ? DW'(wv[e - 1]) : DW'($urandom);
    end
    n_checks++;
    if (writes < 2) begin
      n_fail++;
      $display("FAIL rst_mid write_timeout: got %0d writes want 2", writes);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({if_sat.write_en, if_sat.done, if_sat.err, if_sat.ovf, if_sat.busy} !== 5'b0 ||
        if_sat.address !== AW'(OUT_BASE) || if_sat.data_out !== '0) begin
      n_fail++;
      $display("FAIL rst_mid outputs: got we%b d%b e%b o%b b%b a%0d q%0d want reset values",
               if_sat.write_en, if_sat.done, if_sat.err, if_sat.ovf, if_sat.busy,
               if_sat.address, if_sat.data_out);
    end
    rst = 1'b0;
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (if_sat.write_en !== 1'b0 || if_sat.done !== 1'b0 || if_sat.busy !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL rst_mid quiet: got %0d active cycles want 0", stray);
    end
    wv = '{1, 2, 3, 4, 5, 6, 7, 8};
    run_op(8'd2, 1'b0, "mul_after_rst");
  endtask

  task automatic test_random();
    logic [DW-1:0] op_word;
    logic signed [DW-1:0] t;
    bit keep;
    for (int it = 0; it < 40; it++) begin
      op_word = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) op_word = op_word | DW'($urandom_range(1, 31) << 3);
      for (int i = 0; i < 8; i++) begin
        t = DW'($urandom);
        wv[i] = int'(t);
      end
      keep = (it < 39) && ($urandom_range(0, 2) == 0);
      run_op(op_word, keep, "random");
      if (!keep) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_add_sat_wrap();
    test_mul_det();
    test_back_to_back();
    test_illegal();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
